// File: rtl/coeff_bank_pkg.sv
// Shared constants, state encoding and tap-pair packing for the coefficient bank.
package coeff_bank_pkg;

  localparam int NTAPS    = 128;
  localparam int CW       = 18;
  localparam int AW       = 6;
  localparam int NENTRIES = NTAPS / 2;
  localparam int PW       = 2 * CW;
  localparam int WCW      = $clog2(NTAPS);

  // Field positions inside one packed pair: even tap low, odd tap high.
  localparam int EVEN_LSB = 0;
  localparam int ODD_LSB  = CW;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    FULL    = 2'd2,
    PENDING = 2'd3
  } state_t;

  function automatic logic [PW-1:0] pack_pair(input logic [CW-1:0] even_tap,
                                              input logic [CW-1:0] odd_tap);
    logic [PW-1:0] pair;
    pair                       = '0;
    pair[EVEN_LSB +: CW]       = even_tap;
    pair[ODD_LSB  +: CW]       = odd_tap;
    return pair;
  endfunction

endpackage

// File: rtl/coeff_bank_if.sv
// Filter read port, controller write stream and bank-swap control of the coefficient bank.
interface coeff_bank_if;
  import coeff_bank_pkg::*;

  logic [AW-1:0] coeffaddress;
  logic [PW-1:0] coeff;
  logic          wr_valid;
  logic          wr_ready;
  logic [CW-1:0] wr_data;
  logic          abort;
  logic          commit;
  logic          frame_sync;
  logic          loaded;
  logic          active_bank;
  logic          swap_done;

  modport slave (
    input  coeffaddress, wr_valid, wr_data, abort, commit, frame_sync,
    output coeff, wr_ready, loaded, active_bank, swap_done
  );

  modport master (
    output coeffaddress, wr_valid, wr_data, abort, commit, frame_sync,
    input  coeff, wr_ready, loaded, active_bank, swap_done
  );

endinterface

// File: rtl/coeff_bank_ram.sv
// Two-bank pair storage: one write port, one registered read port, cleared by reset.
module coeff_bank_ram
  import coeff_bank_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  logic          wr_bank,
  input  logic [AW-1:0] wr_addr,
  input  logic [PW-1:0] wr_data,
  input  logic          rd_bank,
  input  logic [AW-1:0] rd_addr,
  output logic [PW-1:0] rd_data
);

  logic [PW-1:0] mem_reg [2][NENTRIES];
  logic [PW-1:0] rd_data_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int e = 0; e < NENTRIES; e++) begin
          mem_reg[b][e] <= '0;
        end
      end
    end else if (wr_en) begin
      mem_reg[wr_bank][wr_addr] <= wr_data;
    end
  end

  // Out-of-range addresses read as zero; only reachable if AW exceeds the entry count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_data_reg <= '0;
    end else if ({1'b0, rd_addr} < (AW+1)'(NENTRIES)) begin
      rd_data_reg <= mem_reg[rd_bank][rd_addr];
    end else begin
      rd_data_reg <= '0;
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/coeff_bank.sv
// Double-buffered FIR coefficient store: streams a new set into the shadow bank and
// swaps it in only at a frame boundary.
module coeff_bank
  import coeff_bank_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  coeff_bank_if.slave  bus
);

  state_t         state_reg;
  logic [WCW-1:0] wcnt_reg;
  logic [CW-1:0]  hold_reg;
  logic           active_bank_reg;
  logic           loaded_reg;
  logic           swap_done_reg;
  logic           wr_ready_reg;

  logic           accept;
  logic           last_word;
  logic           do_abort;
  logic           do_swap;
  logic           ram_we;
  logic [AW-1:0]  ram_waddr;
  logic [PW-1:0]  ram_wdata;
  logic [PW-1:0]  coeff_q;

  // A word offered alongside abort is dropped even when there is nothing to abort.
  assign accept    = bus.wr_valid && wr_ready_reg && !bus.abort;
  assign last_word = accept && (wcnt_reg == WCW'(NTAPS - 1));
  assign do_abort  = bus.abort && (state_reg != IDLE);
  assign do_swap   = !bus.abort && bus.frame_sync &&
                     ((state_reg == PENDING) || ((state_reg == FULL) && bus.commit));

  assign ram_we    = accept && wcnt_reg[0];
  assign ram_waddr = wcnt_reg[WCW-1:1];
  assign ram_wdata = pack_pair(hold_reg, bus.wr_data);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      wcnt_reg        <= '0;
      hold_reg        <= '0;
      active_bank_reg <= 1'b0;
      loaded_reg      <= 1'b0;
      swap_done_reg   <= 1'b0;
      wr_ready_reg    <= 1'b1;
    end else begin
      swap_done_reg <= 1'b0;
      if (accept) begin
        wcnt_reg <= wcnt_reg + 1'b1;
        if (!wcnt_reg[0]) begin
          hold_reg <= bus.wr_data;
        end
      end
      if (do_abort) begin
        state_reg    <= IDLE;
        wcnt_reg     <= '0;
        loaded_reg   <= 1'b0;
        wr_ready_reg <= 1'b1;
      end else begin
        case (state_reg)
          IDLE: begin
            if (accept) begin
              state_reg <= LOAD;
            end
          end
          LOAD: begin
            if (last_word) begin
              state_reg    <= FULL;
              loaded_reg   <= 1'b1;
              wr_ready_reg <= 1'b0;
            end
          end
          FULL, PENDING: begin
            if (do_swap) begin
              state_reg       <= IDLE;
              active_bank_reg <= !active_bank_reg;
              swap_done_reg   <= 1'b1;
              loaded_reg      <= 1'b0;
              wcnt_reg        <= '0;
              wr_ready_reg    <= 1'b1;
            end else if ((state_reg == FULL) && bus.commit) begin
              state_reg <= PENDING;
            end
          end
          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

  // Writes always target the bank the filter is not reading.
  coeff_bank_ram u_ram (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (ram_we),
    .wr_bank (!active_bank_reg),
    .wr_addr (ram_waddr),
    .wr_data (ram_wdata),
    .rd_bank (active_bank_reg),
    .rd_addr (bus.coeffaddress),
    .rd_data (coeff_q)
  );

  assign bus.coeff       = coeff_q;
  assign bus.wr_ready    = wr_ready_reg;
  assign bus.loaded      = loaded_reg;
  assign bus.active_bank = active_bank_reg;
  assign bus.swap_done   = swap_done_reg;

endmodule
